// File: rtl/dual_addr_ram_clr.sv
// Parametrised RAM: one write port with read-before-write readback (y), one read port (q),
// hardware zero-fill sequencer after reset. Optional q pipeline stage: DUAL_ADDR_RAM_OUT_REG_EN.
module dual_addr_ram_clr #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 7,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] y,
  input  logic              re,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [0:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              rd_vld_q, rd_vld_d;

  logic              busy_s;
  logic              wr_acc_s;
  logic              rd_acc_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic [DATA_W-1:0] old_w_s;
  logic [DATA_W-1:0] old_r_s;

  always_comb begin
    busy_s      = (state_q == ST_CLEAR);
    wr_acc_s    = we & ~busy_s;
    rd_acc_s    = re & ~busy_s;
    old_w_s     = mem[write_addr];
    old_r_s     = mem[read_addr];
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_we_s    = 1'b0;
    mem_addr_s  = write_addr;
    mem_wdata_s = data;
    // The clear sequencer owns the write port while busy; user writes are dropped.
    if (busy_s) begin
      mem_we_s    = 1'b1;
      mem_addr_s  = cnt_q;
      mem_wdata_s = '0;
      cnt_d       = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      if (cnt_q == LAST_ADDR) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_CLEAR;
      end
    end else begin
      mem_we_s = wr_acc_s;
    end
    y_d = wr_acc_s ? old_w_s : y_q;
    if (rd_acc_s) begin
      if ((RDW_MODE != 0) && wr_acc_s && (read_addr == write_addr)) begin
        rd_d = data;
      end else begin
        rd_d = old_r_s;
      end
    end else begin
      rd_d = rd_q;
    end
    rd_vld_d = rd_acc_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RESET;
      cnt_q    <= '0;
      y_q      <= '0;
      rd_q     <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      rd_q     <= rd_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we_s) begin
      mem[mem_addr_s] <= mem_wdata_s;
    end
  end

`ifdef DUAL_ADDR_RAM_OUT_REG_EN
  logic [DATA_W-1:0] q_pipe_q, q_pipe_d;
  logic              qv_pipe_q, qv_pipe_d;

  always_comb begin
    q_pipe_d  = rd_q;
    qv_pipe_d = rd_vld_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_pipe_q  <= '0;
      qv_pipe_q <= 1'b0;
    end else begin
      q_pipe_q  <= q_pipe_d;
      qv_pipe_q <= qv_pipe_d;
    end
  end

  assign q       = q_pipe_q;
  assign q_valid = qv_pipe_q;
`else
  assign q       = rd_q;
  assign q_valid = rd_vld_q;
`endif

  assign y    = y_q;
  assign busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_dual_addr_ram_clr.sv
// Directed self-checking bench for dual_addr_ram_clr (default parameters).
module tb_dual_addr_ram_clr;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 7;
  localparam int RDW_MODE = 0;
`ifdef DUAL_ADDR_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              we = 1'b0;
  logic [ADDR_W-1:0] write_addr = '0;
  logic [DATA_W-1:0] data = '0;
  logic [DATA_W-1:0] y;
  logic              re = 1'b0;
  logic [ADDR_W-1:0] read_addr = '0;
  logic [DATA_W-1:0] q;
  logic              q_valid;
  logic              busy;

  int total = 0;
  int bad   = 0;

  dual_addr_ram_clr #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RDW_MODE(RDW_MODE), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst(rst), .we(we), .write_addr(write_addr), .data(data), .y(y),
    .re(re), .read_addr(read_addr), .q(q), .q_valid(q_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles until busy falls (bounded).
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic issue_read(input logic [ADDR_W-1:0] a);
    re = 1'b1; read_addr = a;
    tick();
    re = 1'b0;
    for (int i = 1; i < LAT; i++) tick();
  endtask

  task automatic issue_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    we = 1'b1; write_addr = a; data = d;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    logic [ADDR_W-1:0] addrs [3];
    addrs[0] = 7'd0; addrs[1] = 7'd64; addrs[2] = 7'd127;
    rst = 1'b1;
    tick(); tick();
    total++; if (q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h exp=00", q); end
    total++; if (y !== 8'h00) begin bad++; $display("FAIL reset_y got=%h exp=00", y); end
    total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL reset_qv got=%b exp=0", q_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", busy); end
    rst = 1'b0;
    count_busy(n);
    total++; if (n != 128) begin bad++; $display("FAIL clear_len got=%0d exp=128", n); end
    for (int k = 0; k < 3; k++) begin
      issue_read(addrs[k]);
      total++;
      if (q_valid !== 1'b1 || q !== 8'h00) begin
        bad++; $display("FAIL clear_read a=%0d got q=%h v=%b exp q=00 v=1", addrs[k], q, q_valid);
      end
      tick();
      total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL clear_read_pulse got=%b exp=0", q_valid); end
    end
  endtask

  task automatic test_write_readback();
    issue_write(7'd5, 8'hA5);
    total++; if (y !== 8'h00) begin bad++; $display("FAIL wr1_y got=%h exp=00", y); end
    issue_write(7'd5, 8'h3C);
    total++; if (y !== 8'hA5) begin bad++; $display("FAIL wr2_y got=%h exp=A5", y); end
    tick();
    total++; if (y !== 8'hA5) begin bad++; $display("FAIL y_hold got=%h exp=A5", y); end
    issue_read(7'd5);
    total++; if (q !== 8'h3C || q_valid !== 1'b1) begin bad++; $display("FAIL rd5 got q=%h v=%b exp q=3C v=1", q, q_valid); end
    tick();
    total++; if (q !== 8'h3C || q_valid !== 1'b0) begin bad++; $display("FAIL q_hold got q=%h v=%b exp q=3C v=0", q, q_valid); end
  endtask

  task automatic test_rdw();
    logic [DATA_W-1:0] exp_q;
    exp_q = (RDW_MODE != 0) ? 8'h22 : 8'h11;
    issue_write(7'd9, 8'h11);
    we = 1'b1; write_addr = 7'd9; data = 8'h22;
    re = 1'b1; read_addr = 7'd9;
    tick();
    we = 1'b0; re = 1'b0;
    total++; if (y !== 8'h11) begin bad++; $display("FAIL rdw_y got=%h exp=11", y); end
    for (int i = 1; i < LAT; i++) tick();
    total++; if (q !== exp_q || q_valid !== 1'b1) begin bad++; $display("FAIL rdw_q got q=%h v=%b exp q=%h v=1", q, q_valid, exp_q); end
    // Independent ports in one cycle: write 20, read 5.
    we = 1'b1; write_addr = 7'd20; data = 8'h77;
    re = 1'b1; read_addr = 7'd5;
    tick();
    we = 1'b0; re = 1'b0;
    total++; if (y !== 8'h00) begin bad++; $display("FAIL diff_y got=%h exp=00", y); end
    for (int i = 1; i < LAT; i++) tick();
    total++; if (q !== 8'h3C) begin bad++; $display("FAIL diff_q got=%h exp=3C", q); end
    issue_read(7'd20);
    total++; if (q !== 8'h77) begin bad++; $display("FAIL rd20 got=%h exp=77", q); end
    issue_read(7'd9);
    total++; if (q !== 8'h22) begin bad++; $display("FAIL rd9 got=%h exp=22", q); end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    issue_write(7'd9, 8'h44);
    total++; if (y !== 8'h22) begin bad++; $display("FAIL pre_y got=%h exp=22", y); end
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    total++; if (busy !== 1'b1 || y !== 8'h00) begin bad++; $display("FAIL mid_state got busy=%b y=%h exp busy=1 y=00", busy, y); end
    rst = 1'b1; tick();
    total++; if (q !== 8'h00 || y !== 8'h00 || q_valid !== 1'b0) begin bad++; $display("FAIL mid_rst got q=%h y=%h v=%b exp 00 00 0", q, y, q_valid); end
    rst = 1'b0;
    count_busy(n);
    total++; if (n != 128) begin bad++; $display("FAIL mid_clear_len got=%0d exp=128", n); end
    issue_read(7'd9);
    total++; if (q !== 8'h00) begin bad++; $display("FAIL mid_rd9 got=%h exp=00", q); end
  endtask

  task automatic test_busy_requests();
    int n;
    int pulses;
    issue_write(7'd3, 8'h12);
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    we = 1'b1; write_addr = 7'd3; data = 8'hFF;
    re = 1'b1; read_addr = 7'd3;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (q_valid === 1'b1) pulses++;
    end
    we = 1'b0; re = 1'b0;
    total++; if (pulses != 0) begin bad++; $display("FAIL busy_qv got=%0d exp=0", pulses); end
    total++; if (y !== 8'h00) begin bad++; $display("FAIL busy_y got=%h exp=00", y); end
    count_busy(n);
    total++; if (n != 118) begin bad++; $display("FAIL busy_rest got=%0d exp=118", n); end
    issue_read(7'd3);
    total++; if (q !== 8'h00 || q_valid !== 1'b1) begin bad++; $display("FAIL busy_rd3 got q=%h v=%b exp q=00 v=1", q, q_valid); end
  endtask

  task automatic test_latency();
    int pulses;
    issue_write(7'd127, 8'h5A);
    re = 1'b1; read_addr = 7'd127;
    tick();
    re = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 4; i++) begin
      if (q_valid === 1'b1) pulses++;
      if (i == LAT) begin
        total++;
        if (q !== 8'h5A || q_valid !== 1'b1) begin bad++; $display("FAIL lat_q got q=%h v=%b exp q=5A v=1", q, q_valid); end
      end
      tick();
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL lat_pulses got=%0d exp=1", pulses); end
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_rdw();
    test_reset_mid_clear();
    test_busy_requests();
    test_latency();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
